// File: rtl/lvds_rx_pkg.sv
// Shared constants, state encoding and helpers for the LVDS 7:1 receiver link-bring-up controller.
package lvds_rx_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 7;
    localparam int RETRY_W   = 4;

    localparam logic [LANE_W-1:0] DEFAULT_TRAIN_PATTERN = 7'h63;

    typedef enum logic [2:0] {
        IDLE,
        RESET_RX,
        WAIT_ALIGN,
        VERIFY,
        RETRY,
        LOCKED,
        FAIL
    } align_state_t;

    function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lvds_lane_checker.sv
// Per-lane training-word comparator: registers data==pattern, held at 0 while its enable is low.
module lvds_lane_checker
    import lvds_rx_pkg::*;
(
    input  logic              parallel_clk,
    input  logic              resetn,
    input  logic              en_i,
    input  logic [LANE_W-1:0] pattern_i,
    input  logic [LANE_W-1:0] data_i,
    output logic              lane_ok_o
);

    logic lane_ok_d;
    logic lane_ok_q;

    always_comb begin
        lane_ok_d = en_i && (data_i == pattern_i);
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge parallel_clk) begin
        if (!resetn) begin
            lane_ok_q <= 1'b0;
        end else begin
            lane_ok_q <= lane_ok_d;
        end
    end

    assign lane_ok_o = lane_ok_q;

endmodule

// File: rtl/lvds_rx_align_ctrl.sv
// Link-bring-up sequencer for the 4-lane LVDS 7:1 receiver: reset, wait for alignment, verify training word, lock or retry.
// Optional relock statistics output enabled by defining LVDS_RX_ALIGN_STATS_EN.
module lvds_rx_align_ctrl
    import lvds_rx_pkg::*;
#(
    parameter int unsigned       RST_CYCLES    = 16,
    parameter int unsigned       ALIGN_TIMEOUT = 4096,
    parameter int unsigned       VERIFY_CYCLES = 64,
    parameter int unsigned       MAX_RETRY     = 8,
    parameter logic [LANE_W-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN
) (
    input  logic                        parallel_clk,
    input  logic                        resetn,
    input  logic                        en,
    input  logic                        start,
    input  logic [NUM_LANES-1:0]        align_i,
    input  logic [NUM_LANES*LANE_W-1:0] rdata_i,
    output logic                        rx_resetn_o,
    output logic [LANE_W-1:0]           train_pat_o,
    output logic                        locked_o,
    output logic                        fail_o,
    output logic [NUM_LANES-1:0]        lane_ok_o,
    output logic [RETRY_W-1:0]          retry_cnt_o
`ifdef LVDS_RX_ALIGN_STATS_EN
    ,
    output logic [15:0]                 relock_cnt_o
`endif
);

    localparam int unsigned TMR_MAX = (ALIGN_TIMEOUT > RST_CYCLES) ? ALIGN_TIMEOUT : RST_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned MATCH_W = $clog2(VERIFY_CYCLES + 1);

    localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TO_LAST     = TMR_W'(ALIGN_TIMEOUT - 1);
    localparam logic [MATCH_W-1:0] MATCH_DONE  = MATCH_W'(VERIFY_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
        $error("MAX_RETRY must be within 1..15");
    end

    align_state_t         state_d, state_q;
    logic [TMR_W-1:0]     timer_d, timer_q;
    logic [MATCH_W-1:0]   match_cnt_d, match_cnt_q;
    logic [RETRY_W-1:0]   retry_cnt_d, retry_cnt_q;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 rx_resetn_d, rx_resetn_q;
    logic                 locked_d, locked_q;
    logic                 fail_d, fail_q;
    logic                 lane_en;
    logic [NUM_LANES-1:0] lane_ok;
    logic                 all_aligned;
    logic                 all_match;

    assign all_aligned = &align_i;
    assign all_match   = &lane_ok;
    assign retry_inc   = sat_inc_retry(retry_cnt_q);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        match_cnt_d = '0;
        retry_cnt_d = retry_cnt_q;
        if (!en) begin
            state_d     = IDLE;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = RESET_RX;
                        retry_cnt_d = '0;
                    end
                end
                RESET_RX: begin
                    if (timer_q == RST_LAST) state_d = WAIT_ALIGN;
                    else                     timer_d = timer_q + 1'b1;
                end
                WAIT_ALIGN: begin
                    if (timer_q == TO_LAST) begin
                        state_d = RETRY;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (all_aligned) state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    // The attempt timeout takes priority over a lock reached on the same cycle.
                    if (timer_q == TO_LAST || !all_aligned) begin
                        state_d = RETRY;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (all_match) begin
                            match_cnt_d = match_cnt_q + 1'b1;
                            if (match_cnt_d == MATCH_DONE) state_d = LOCKED;
                        end
                    end
                end
                RETRY: begin
                    retry_cnt_d = retry_inc;
                    state_d     = (retry_inc == RETRY_LIMIT) ? FAIL : RESET_RX;
                end
                LOCKED: begin
                    if (!all_aligned) begin
                        state_d     = RESET_RX;
                        retry_cnt_d = '0;
                    end
                end
                FAIL: begin
                    if (start) begin
                        state_d     = RESET_RX;
                        retry_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change together with the state.
    always_comb begin
        rx_resetn_d = state_d inside {WAIT_ALIGN, VERIFY, RETRY, LOCKED};
        locked_d    = (state_d == LOCKED);
        fail_d      = (state_d == FAIL);
        lane_en     = state_d inside {VERIFY, LOCKED};
    end

    always_ff @(posedge parallel_clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            match_cnt_q <= '0;
            retry_cnt_q <= '0;
            rx_resetn_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            rx_resetn_q <= rx_resetn_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lvds_lane_checker u_lane_checker (
            .parallel_clk (parallel_clk),
            .resetn       (resetn),
            .en_i         (lane_en),
            .pattern_i    (TRAIN_PATTERN),
            .data_i       (rdata_i[i*LANE_W +: LANE_W]),
            .lane_ok_o    (lane_ok[i])
        );
    end

`ifdef LVDS_RX_ALIGN_STATS_EN
    logic [15:0] relock_cnt_d, relock_cnt_q;

    always_comb begin
        relock_cnt_d = relock_cnt_q;
        if (state_q == LOCKED && state_d == RESET_RX && relock_cnt_q != 16'hFFFF) begin
            relock_cnt_d = relock_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge parallel_clk) begin
        if (!resetn) relock_cnt_q <= '0;
        else         relock_cnt_q <= relock_cnt_d;
    end

    assign relock_cnt_o = relock_cnt_q;
`else
    // Relock statistics are compiled out in this build.
`endif

    assign rx_resetn_o = rx_resetn_q;
    assign train_pat_o = TRAIN_PATTERN;
    assign locked_o    = locked_q;
    assign fail_o      = fail_q;
    assign lane_ok_o   = lane_ok;
    assign retry_cnt_o = retry_cnt_q;

endmodule
